int_div_8: RTL
==============

Name: int_div_8

Overview:
- Sequential unsigned integer divider. It is the inverse-operation companion to the board's 8-bit multiplier.
- Takes dividend/divisor from switch-width operands and produces quotient and remainder for LED or display readout.
- Restoring algorithm, one quotient bit per clock, start/busy/done handshake.
- Sits in user space beside the multiplier, driven by top-level glue.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  request a division. Sampled only when the block is not busy.
- dividend  input  WIDTH  numerator. Sampled on the accepting edge only.
- divisor  input  WIDTH  denominator. Sampled on the accepting edge only.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse: results valid this cycle.
- quotient  output  WIDTH  registered quotient. Held until the next completion.
- remainder  output  WIDTH  registered remainder. Held until the next completion.
- div_by_zero  output  1  registered flag for the last completed operation.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal counter and working registers are cleared.
  - Reset has priority over everything else, including mid-CALC; the operation in progress is abandoned and no done is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - busy=0, done=0.
  - If start==1 and divisor!=0: latch operands, clear partial remainder, bit counter=0, go to CALC.
  - If start==1 and divisor==0: go to DONE with the zero-divide result (see below); CALC is skipped.
- CALC:
  - busy=1.
  - Per edge:
    - trial = {partial_rem[WIDTH-2:0], next dividend MSB}, computed at WIDTH+1 bits to avoid overflow.
    - If trial >= divisor: partial_rem = trial - divisor and quotient bit = 1; else partial_rem = trial and quotient bit = 0.
  - After exactly WIDTH CALC edges, go to DONE and load the quotient/remainder output registers.
- DONE:
  - Lasts exactly one cycle.
  - done=1, busy=0; outputs are valid in this cycle.
  - Next state is IDLE, unless start==1 in this cycle. In that case the new operands are accepted exactly as in IDLE (back-to-back operation).
- Latency, counted from the accepting edge (edge 0):
  - Normal division: busy high for WIDTH cycles; done high in the cycle after edge WIDTH+1. This is 9 edges for WIDTH=8.
  - Divide-by-zero: done high in the cycle after edge 1.
- Divide-by-zero result: quotient = all ones, remainder = dividend, div_by_zero=1.
- Any successful completion sets div_by_zero=0.
- start asserted while in CALC is ignored: no queuing, and operands are not re-sampled.
- Changes on dividend/divisor during CALC have no effect.
- Outputs only change on a DONE entry or on reset. Between completions they hold the last results.
- Results satisfy quotient*divisor + remainder == dividend, with remainder < divisor, for every divisor != 0.
- Edge cases:
  - dividend=0 gives q=0, r=0.
  - divisor > dividend gives q=0, r=dividend.
  - divisor=1 gives q=dividend, r=0.

Test Plan:
- Reset held low 3 cycles, then released -> all outputs 0, busy=0, done=0; no done pulse without start.
- dividend=200, divisor=7, start pulsed 1 cycle -> busy for 8 cycles; done pulse 9 edges after acceptance with quotient=28, remainder=4, div_by_zero=0; outputs held afterwards.
- dividend=5, divisor=0 -> done on the 2nd edge with quotient=255, remainder=5, div_by_zero=1. Then 255/1 -> quotient=255, remainder=0, div_by_zero cleared.
- Operand corners: 3/10 -> q=0, r=3. 0/9 -> q=0, r=0. 255/255 -> q=1, r=0. 128/2 -> q=64, r=0.
- 100/9 started; start re-pulsed with 50/5 during CALC -> ignored, result q=11, r=1. start held high through DONE with 50/5 -> back-to-back acceptance, q=10, r=0 nine edges later.
- 200/7 started; reset asserted at CALC edge 4 -> busy=0 and all outputs 0 next cycle, no done pulse; a fresh 9/3 then yields q=3, r=0.
- Random sweep of ≥1000 operand pairs -> checked against the reference model q=a/b, r=a%b (b=0 per the zero-divide rule).

Source files
------------

// File: rtl/int_div_8.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// A zero divisor skips the iteration and returns all-ones quotient with the dividend as remainder.
module int_div_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] part_r;
    logic [WIDTH-1:0] qwork_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic             dbz_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             zero_div_s;
    logic             last_s;
    logic [WIDTH:0]   trial_s;
    logic             ge_s;
    logic [WIDTH-1:0] part_next_s;

    // Next-state selection; IDLE and DONE both accept a new request.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        zero_div_s   = (divisor == {WIDTH{1'b0}});
        last_s       = (count_r == LAST_BIT);
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    if (zero_div_s) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = CALC;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = CALC;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    // The partial remainder is always below the divisor, so the trial fits in WIDTH+1 bits.
    always_comb begin
        trial_s = {part_r, dvd_r[WIDTH-1]};
        ge_s    = (trial_s >= {1'b0, dvs_r});
        if (ge_s) begin
            part_next_s = trial_s[WIDTH-1:0] - dvs_r;
        end else begin
            part_next_s = trial_s[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= {CW{1'b0}};
            dvd_r   <= {WIDTH{1'b0}};
            dvs_r   <= {WIDTH{1'b0}};
            part_r  <= {WIDTH{1'b0}};
            qwork_r <= {WIDTH{1'b0}};
            quot_r  <= {WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            dbz_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        dvd_r   <= dividend;
                        dvs_r   <= divisor;
                        part_r  <= {WIDTH{1'b0}};
                        qwork_r <= {WIDTH{1'b0}};
                        count_r <= {CW{1'b0}};
                        if (zero_div_s) begin
                            quot_r <= {WIDTH{1'b1}};
                            rem_r  <= dividend;
                            dbz_r  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dvd_r   <= {dvd_r[WIDTH-2:0], 1'b0};
                    part_r  <= part_next_s;
                    qwork_r <= {qwork_r[WIDTH-2:0], ge_s};
                    count_r <= count_r + CW'(1'b1);
                    if (last_s) begin
                        quot_r <= {qwork_r[WIDTH-2:0], ge_s};
                        rem_r  <= part_next_s;
                        dbz_r  <= 1'b0;
                    end
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Handshake flags trail the state by one cycle so done coincides with settled results.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_r == CALC);
            done_r <= (state_r == DONE);
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quot_r;
    assign remainder   = rem_r;
    assign div_by_zero = dbz_r;

endmodule
